// File: rtl/lfsr_step_sched.sv
// -----------------------------------------------------------------------------
// lfsr_step_sched
//
// Command-driven sequencer around an 8-bit XNOR up/down LFSR. One command is
// taken at a time: LOAD a seed, or STEP the register N positions forward (up)
// or backward (down), one position per clock, freezing while pause is high.
// Target-value hits are counted during a run. The final state and the hit
// count are returned on a valid/ready response channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The sender holds its payload stable while valid && !ready.
// cmd_ready is a combinational function of state and reset only; rsp_valid is
// a function of state only, so neither depends on the partner's signal.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   cmd_valid  command offered
//   cmd_ready  block can accept a command (IDLE and reset released)
//   cmd_op     0=LOAD, 1=STEP_UP, 2=STEP_DOWN, 3=reserved (STEP of 0)
//   cmd_arg    LOAD: seed value; STEP: step count N (0 legal)
//   pause      freezes stepping while high
//   rsp_valid  response available
//   rsp_ready  response consumed
//   rsp_data   LFSR state at end of command (0 when no response is offered)
//   rsp_hits   saturating target-hit count (0 when no response is offered)
//   lfsr_q     live registered LFSR state
//   busy       high in RUN or RESP
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=RESP)
// -----------------------------------------------------------------------------
module lfsr_step_sched #(
   parameter int HIT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [7:0]       cmd_arg,
   input  logic             pause,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic [HIT_W-1:0] rsp_hits,
   output logic [7:0]       lfsr_q,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0]       OP_LOAD = 2'd0;
   localparam logic [1:0]       OP_UP   = 2'd1;
   localparam logic [1:0]       OP_DOWN = 2'd2;
   localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_lfsr;
   logic [7:0]       r_rem;
   logic             r_down;
   logic [HIT_W-1:0] r_hits;

   logic             w_accept;
   logic             w_is_step;
   logic             w_step;
   logic             w_last;
   logic [7:0]       w_up;
   logic [7:0]       w_dn;
   logic [7:0]       w_next;
   logic [7:0]       w_target;

   // Up shifts right feeding the XNOR of taps 0x63 into bit 7; down shifts
   // left feeding taps 0xB1 into bit 0, which exactly undoes the up step.
   assign w_up     = {~^(r_lfsr & 8'h63), r_lfsr[7:1]};
   assign w_dn     = {r_lfsr[6:0], ~^(r_lfsr & 8'hB1)};
   assign w_next   = r_down ? w_dn : w_up;
   assign w_target = r_down ? 8'h80 : 8'h01;

   // Reserved op and zero-length steps skip RUN entirely.
   assign w_is_step = ((cmd_op == OP_UP) || (cmd_op == OP_DOWN)) && (cmd_arg != 8'd0);
   assign w_step    = (r_state == ST_RUN) && !pause;
   assign w_last    = w_step && (r_rem == 8'd1);

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      rsp_valid   = 1'b0;
      busy        = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = reset;
            w_accept  = cmd_valid && reset;
            if (w_accept) begin
               w_state_nxt = w_is_step ? ST_RUN : ST_RESP;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_lfsr  <= 8'h00;
         r_rem   <= 8'd0;
         r_down  <= 1'b0;
         r_hits  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_hits <= '0;
            r_down <= (cmd_op == OP_DOWN);
            if (cmd_op == OP_LOAD) begin
               r_lfsr <= cmd_arg;
            end
            if (w_is_step) begin
               r_rem <= cmd_arg;
            end
         end else if (w_step) begin
            r_lfsr <= w_next;
            r_rem  <= r_rem - 8'd1;
            // A hit is judged on the post-step value.
            if ((w_next == w_target) && (r_hits != HIT_MAX)) begin
               r_hits <= r_hits + 1'b1;
            end
         end
      end
   end

   assign rsp_data  = rsp_valid ? r_lfsr : 8'h00;
   assign rsp_hits  = rsp_valid ? r_hits : '0;
   assign lfsr_q    = r_lfsr;
   assign dbg_state = r_state;

endmodule

// File: doc/lfsr_step_sched.md
Name: lfsr_step_sched

Overview:
- Command-driven sequencer for an 8-bit XNOR up/down LFSR state register held inside the block.
- Accepts one command at a time: seed load, or run N forward/backward steps.
- Steps the LFSR one position per clock, honouring a pause input, and counts target-value hits during the run.
- Returns final state and hit count on a valid/ready response channel; sits between a test/config master and PRBS consumers.

Parameters:
HIT_W, 8, width of the saturating hit counter (rsp_hits); legal range 1..8

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept command
cmd_op  input  2  0=LOAD, 1=STEP_UP, 2=STEP_DOWN, 3=reserved (treated as STEP of 0)
cmd_arg  input  8  LOAD: seed value; STEP: step count N (0 legal)
pause  input  1  freezes stepping while high
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_data  output  8  LFSR state at end of command
rsp_hits  output  HIT_W  target hits during command, saturating
lfsr_q  output  8  live LFSR state
busy  output  1  high in RUN or RESP

Behaviour:
- Up step: next = {~^(q & 8'h63), q[7:1]}. Down step: next = {q[6:0], ~^(q & 8'hB1)}. Down is exact inverse of up.
- Hit target: 8'h01 for STEP_UP, 8'h80 for STEP_DOWN. Hit counted when the post-step value equals the target.
- Hit counter clears on command acceptance and saturates at 2^HIT_W-1.
- Reset (reset==0 at edge):
  - state=IDLE, lfsr_q=8'h00, step counter=0, rsp_valid=0, rsp_data=0, rsp_hits=0, busy=0.
  - cmd_ready=0 while reset is low.
  - Reset in any state aborts the run; no response is issued.
- FSM IDLE/RUN/RESP:
  - cmd_ready = (state==IDLE) && reset.
  - IDLE, accept (cmd_valid&&cmd_ready):
    - LOAD: lfsr_q<=cmd_arg, hits<=0, go to RESP.
    - STEP with N>0: latch direction, remaining<=N, go to RUN.
    - STEP with N==0, or op 3: go to RESP with lfsr_q unchanged and hits=0.
  - RUN: each clock with pause==0, perform one step and remaining-1. Clock with pause==1: no state change.
  - RUN: the step that makes remaining reach 0 also moves to RESP.
  - RESP: rsp_valid=1; rsp_data=lfsr_q, rsp_hits stable while rsp_valid&&!rsp_ready. On rsp_ready, go to IDLE next cycle.
- Latency:
  - Accept in cycle C0. Unpaused STEP N: steps occur at the ends of C1..CN; rsp_valid is high from C(N+1).
  - LOAD or N==0: rsp_valid is high from C1.
  - Each paused cycle adds one cycle.
- cmd_ready is low during RUN and RESP, and in the cycle rsp_ready is taken. Next command is accepted at the earliest one cycle after the handshake.
- 8'hFF is the XNOR lock-up state (maps to itself both directions); no special handling.
- cmd_arg=255 runs 255 steps; no wrap of the step counter.
- lfsr_q is always the registered state; it changes only on LOAD accept or on a RUN step.

Test Plan:
- Reset, STEP_UP N=4, rsp_ready=1 -> lfsr_q sequence 80,C0,60,B0; rsp_valid rises in C5; rsp_data=8'hB0, rsp_hits=0.
- LOAD 8'hB0 then STEP_DOWN N=4 -> sequence 60,C0,80,00; rsp_data=8'h00, rsp_hits=1; LOAD response in C1 with rsp_data=8'hB0.
- LOAD 8'hFF, STEP_UP N=3 -> rsp_data=8'hFF, rsp_hits=0. STEP_UP N=0 -> rsp_valid in C1, rsp_data=8'hFF.
- From reset, STEP_UP N=4 with pause high in C2 and C3 -> rsp_valid in C7, rsp_data=8'hB0; lfsr_q holds 8'h80 during pause.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_hits stable, cmd_ready=0, a new cmd_valid is not accepted; after handshake, cmd_ready returns the next cycle.
- Assert reset=0 mid-RUN (STEP_UP N=10, after 3 steps) -> next cycle lfsr_q=8'h00, rsp_valid=0, busy=0, no response; after reset release, cmd_ready=1.
